// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker
//   On-board self-test for a WIDTH-bit combinational (or short-latency) adder.
//   It walks every operand pair, with A as the outer loop and B as the inner
//   loop, and holds each pair for DWELL cycles. On the last cycle of each hold
//   it compares the adder's {cout,S} against A+B. It then reports pass/fail, a
//   saturating error count, and the first failing pair.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        one-cycle sweep request, honoured in IDLE or DONE only
//   A, B         operands driven to the adder under test
//   S, cout      adder sum and carry out
//   busy         sweep in progress
//   done         sweep finished; held until the next start or rst
//   pass         valid while done=1, set when no mismatch was seen
//   err_count    number of mismatching pairs, saturating at all-ones
//   first_err_A  A of the first mismatching pair, 0 if none
//   first_err_B  B of the first mismatching pair, 0 if none
//
// States
//   IDLE | waiting for start after reset
//   HOLD | presenting a pair, compare on last dwell cycle
//   DONE | sweep complete, results held

module adder_sweep_checker #(
  parameter int WIDTH = 4,
  parameter int DWELL = 4   // legal range 1..255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   S,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_A,
  output logic [WIDTH-1:0]   first_err_B
);

  localparam int EW = 2*WIDTH + 1;
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [WIDTH-1:0] OP_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] OP_ONE     = WIDTH'(1);
  localparam logic [EW-1:0]    ERR_MAX    = {EW{1'b1}};
  localparam logic [EW-1:0]    ERR_ONE    = EW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             start_q;
  logic [7:0]       dwell_cnt, dwell_cnt_next;
  logic [WIDTH-1:0] a_next, b_next;
  logic [WIDTH-1:0] fa_next, fb_next;
  logic [EW-1:0]    err_next, err_after;
  logic             pass_next;
  logic [WIDTH:0]   sum_ref;
  logic             mismatch;
  logic             at_compare;

  // The request is registered, so a sweep begins on the edge after the one
  // that samples start. The start-to-done latency is therefore
  // 1 + pairs*DWELL. Requests seen during a sweep are dropped here, so they
  // cannot leak into DONE and cause a spurious restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      dwell_cnt   <= '0;
      A           <= '0;
      B           <= '0;
      err_count   <= '0;
      first_err_A <= '0;
      first_err_B <= '0;
      pass        <= 1'b0;
    end else begin
      state       <= state_next;
      start_q     <= start && (state != HOLD);
      dwell_cnt   <= dwell_cnt_next;
      A           <= a_next;
      B           <= b_next;
      err_count   <= err_next;
      first_err_A <= fa_next;
      first_err_B <= fb_next;
      pass        <= pass_next;
    end
  end

  assign sum_ref    = {1'b0, A} + {1'b0, B};
  assign mismatch   = ({cout, S} != sum_ref);
  assign at_compare = (dwell_cnt == DWELL_LAST);

  always_comb begin
    state_next     = state;
    dwell_cnt_next = dwell_cnt;
    a_next         = A;
    b_next         = B;
    err_next       = err_count;
    fa_next        = first_err_A;
    fb_next        = first_err_B;
    pass_next      = pass;
    err_after      = err_count;

    case (state)
      IDLE, DONE: begin
        if (start_q) begin
          state_next     = HOLD;
          dwell_cnt_next = '0;
          a_next         = '0;
          b_next         = '0;
          err_next       = '0;
          fa_next        = '0;
          fb_next        = '0;
          pass_next      = 1'b0;
        end
      end
      HOLD: begin
        if (at_compare) begin
          dwell_cnt_next = '0;
          if (mismatch) begin
            if (err_count != ERR_MAX) err_after = err_count + ERR_ONE;
            // A zero count means no earlier mismatch, because the count
            // saturates and never wraps back to zero.
            if (err_count == '0) begin
              fa_next = A;
              fb_next = B;
            end
          end
          err_next = err_after;
          if ((A == OP_ONES) && (B == OP_ONES)) begin
            state_next = DONE;
            pass_next  = (err_after == '0);
          end else if (B != OP_ONES) begin
            b_next = B + OP_ONE;
          end else begin
            b_next = '0;
            a_next = A + OP_ONE;
          end
        end else begin
          dwell_cnt_next = dwell_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == HOLD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_adder_sweep_checker.sv
module tb_adder_sweep_checker;

  localparam int W  = 4;
  localparam int EW = 2*W + 1;
  localparam int NPAIRS = 1 << (2*W);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start0 = 1'b0, start1 = 1'b0;
  logic [1:0] fault0 = 2'd0, fault1 = 2'd0;

  logic [W-1:0]  a0, b0, s0, fa0, fb0, a1, b1, s1, fa1, fb1;
  logic          c0, c1, busy0, busy1, done0, done1, pass0, pass1;
  logic [EW-1:0] err0, err1;

  // Reference adder under test. fault 1 = S[0] stuck at 0, 2 = cout stuck at 0.
  function automatic logic [W:0] adder(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] f);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b};
    if (f == 2'd1) r[0] = 1'b0;
    if (f == 2'd2) r[W] = 1'b0;
    return r;
  endfunction

  assign {c0, s0} = adder(a0, b0, fault0);
  assign {c1, s1} = adder(a1, b1, fault1);

  adder_sweep_checker #(.WIDTH(W), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .S(s0), .cout(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_A(fa0), .first_err_B(fb0)
  );

  adder_sweep_checker #(.WIDTH(W), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .S(s1), .cout(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_A(fa1), .first_err_B(fb1)
  );

  // Selected-instance views so one sweep task serves both instances.
  logic          sel = 1'b0;
  logic [W-1:0]  x_a, x_b, x_fa, x_fb;
  logic          x_busy, x_done, x_pass;
  logic [EW-1:0] x_err;
  assign x_a    = sel ? a1    : a0;
  assign x_b    = sel ? b1    : b0;
  assign x_fa   = sel ? fa1   : fa0;
  assign x_fb   = sel ? fb1   : fb0;
  assign x_busy = sel ? busy1 : busy0;
  assign x_done = sel ? done1 : done0;
  assign x_pass = sel ? pass1 : pass0;
  assign x_err  = sel ? err1  : err0;

  typedef struct {
    string         tag;
    int            lat;
    logic          pass;
    logic [EW-1:0] err;
    logic [W-1:0]  fa;
    logic [W-1:0]  fb;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected sweep outcome from an exhaustive walk of the reference adder.
  task automatic push_expect(input string tag, input int dwell, input logic [1:0] f);
    exp_t e;
    logic [W:0] good, got;
    e.tag = tag;
    e.lat = 1 + NPAIRS*dwell;
    e.err = '0;
    e.fa  = '0;
    e.fb  = '0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        good = (W+1)'(a) + (W+1)'(b);
        got  = adder(W'(a), W'(b), f);
        if (got != good) begin
          if (e.err == '0) begin
            e.fa = W'(a);
            e.fb = W'(b);
          end
          e.err = e.err + EW'(1);
        end
      end
    end
    e.pass = (e.err == '0);
    sbq.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Start a sweep and count edges until done. Optionally re-pulse start at
  // cycle restart_at, and optionally check the A/B walk on every cycle.
  task automatic run_sweep(input int dwell, input int restart_at, input bit walk);
    int n;
    int idx;
    exp_t e;
    pulse_start();
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (n == restart_at) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (walk && n <= NPAIRS*dwell) begin
        idx = (n - 1) / dwell;
        chk("walk_A", 32'(x_a), 32'(idx >> W));
        chk("walk_B", 32'(x_b), 32'(idx % (1 << W)));
      end
      if (x_done) break;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({e.tag, "_done"},    32'(x_done), 32'(1));
      chk({e.tag, "_busy"},    32'(x_busy), 32'(0));
      chk({e.tag, "_pass"},    32'(x_pass), 32'(e.pass));
      chk({e.tag, "_err"},     32'(x_err),  32'(e.err));
      chk({e.tag, "_fa"},      32'(x_fa),   32'(e.fa));
      chk({e.tag, "_fb"},      32'(x_fb),   32'(e.fb));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_A"},    32'(x_a),    32'(0));
    chk({tag, "_B"},    32'(x_b),    32'(0));
    chk({tag, "_busy"}, 32'(x_busy), 32'(0));
    chk({tag, "_done"}, 32'(x_done), 32'(0));
    chk({tag, "_pass"}, 32'(x_pass), 32'(0));
    chk({tag, "_err"},  32'(x_err),  32'(0));
    chk({tag, "_fa"},   32'(x_fa),   32'(0));
    chk({tag, "_fb"},   32'(x_fb),   32'(0));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 1'b0;
    #1;
    check_idle("reset");

    // Correct adder, full walk checked
    fault0 = 2'd0;
    push_expect("good", 4, 2'd0);
    run_sweep(4, 0, 1'b1);

    // S[0] stuck at 0, restarted from DONE
    fault0 = 2'd1;
    push_expect("s0_stuck", 4, 2'd1);
    run_sweep(4, 0, 1'b0);

    // cout stuck at 0
    fault0 = 2'd2;
    push_expect("cout_stuck", 4, 2'd2);
    run_sweep(4, 0, 1'b0);

    // start re-pulsed mid-sweep (around A=3) must be ignored
    fault0 = 2'd1;
    push_expect("restart_ignored", 4, 2'd1);
    run_sweep(4, 200, 1'b0);

    // rst in the middle of a faulty sweep, then a clean sweep
    pulse_start();
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("mid_reset_stays_idle", 32'(x_busy), 32'(0));
    fault0 = 2'd0;
    push_expect("after_reset", 4, 2'd0);
    run_sweep(4, 0, 1'b1);

    // DWELL=1 instance: clean run, then restart from DONE with S[0] fault
    sel = 1'b1;
    #1;
    fault1 = 2'd0;
    push_expect("dwell1_good", 1, 2'd0);
    run_sweep(1, 0, 1'b1);
    fault1 = 2'd1;
    push_expect("dwell1_s0_stuck", 1, 2'd1);
    run_sweep(1, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adder_sweep_checker.md
Name: adder_sweep_checker

Overview:
- Self-contained sequential stimulus/check stage that drives the operand inputs of the team's WIDTH-bit adder and consumes its sum/carry outputs.
- Sweeps every operand pair (A outer loop, B inner loop) and holds each pair for DWELL cycles. Compares {cout,S} against A+B and reports pass/fail, error count and first failing pair.
- Replaces hand-written per-vector stimulus with a synthesizable, reusable on-board self-test.

Parameters:
- WIDTH, 4: operand width of the adder under test.
- DWELL, 4: cycles each operand pair is held before sampling; legal range 1..255.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- A  output  WIDTH  operand A driven to the adder.
- B  output  WIDTH  operand B driven to the adder.
- S  input  WIDTH  adder sum.
- cout  input  1  adder carry out.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep end until next start or rst.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching pairs; saturates at all-ones.
- first_err_A  output  WIDTH  A of the first mismatch; 0 if none.
- first_err_B  output  WIDTH  B of the first mismatch; 0 if none.

Behaviour:
- Reset, applied any cycle including mid-sweep:
  - state=IDLE; A, B, busy, done, pass, err_count, first_err_A and first_err_B all 0.
  - Dwell counter cleared.
- States: IDLE, HOLD, DONE.
- IDLE, start=1 at edge k:
  - At k+1: state=HOLD, busy=1, A=0, B=0, dwell counter=0.
  - err_count and first_err_* cleared; done=0, pass=0.
- HOLD:
  - Dwell counter increments each cycle.
  - On the cycle the counter equals DWELL-1, compare {cout,S} (WIDTH+1 bits) with zero-extended A+B (WIDTH+1 bits).
  - On mismatch:
    - err_count increments, saturating.
    - If this is the first error of the sweep, latch A and B into first_err_*.
- HOLD, advance (same edge as the compare):
  - Counter returns to 0.
  - If B != all-ones: B increments.
  - Else B=0 and A increments.
- Last pair: if A and B are both all-ones at the compare edge, next state=DONE.
  - busy=0, done=1.
  - pass=1 iff the final err_count (including this compare) is 0.
  - A and B hold their last values.
- Each pair is presented for exactly DWELL cycles. Start-to-done latency = 1 + 2^(2*WIDTH)*DWELL cycles; 1025 for the defaults.
- DONE: outputs are held. start=1 restarts exactly as from IDLE, with all results cleared.
- start while busy is ignored; the sweep is neither restarted nor altered.
- The adder is assumed combinational. DWELL covers any registered latency the adder may have, up to DWELL-1 cycles.
- Widths: err_count is 2*WIDTH+1 bits, so 2^(2*WIDTH) errors fit; saturation only matters if WIDTH is changed inconsistently.

Test Plan:
- Correct adder model, defaults; pulse start:
  - done rises exactly 1025 cycles after the start edge.
  - pass=1, err_count=0, first_err_A/B=0.
  - A,B walk 0/0, 0/1 … 15/15, changing every 4 cycles.
- S[0] stuck at 0:
  - done with pass=0, err_count=128.
  - first_err_A=0, first_err_B=1.
- cout stuck at 0:
  - err_count=120, i.e. the pairs with A+B>=16.
  - first_err_A=1, first_err_B=15.
- start pulsed again mid-sweep (e.g. at A=3):
  - Ignored; the sweep completes at the original 1025-cycle mark with unchanged results.
- rst asserted mid-sweep, then start:
  - After rst, all outputs are 0 and state=IDLE.
  - The new sweep starts from A=0,B=0 and completes normally.
- DWELL=1, correct model; then restart from DONE with the S[0] fault:
  - First run completes in 257 cycles with pass=1.
  - Second run clears the previous results and ends with err_count=128.
